// File: rtl/multi_key_debounce.sv
// Multi-channel key debouncer: 2-flop synchroniser, tick-sampled stability filter,
// press/release edge pulses and a per-channel long-press / auto-repeat FSM.
module multi_key_debounce #(
   parameter int CHANNELS           = 4,
   parameter int CLK_HZ             = 50_000_000,
   parameter int SAMPLE_HZ          = 100,
   parameter int STABLE_SAMPLES     = 8,
   parameter int ACTIVE_LOW         = 1,
   parameter int LONG_PRESS_SAMPLES = 100,
   parameter int REPEAT_SAMPLES     = 20
) (
   input  logic                  Clk_50Mhz,
   input  logic                  Rst_n,
   input  logic [CHANNELS-1:0]   Raw,
   output logic [CHANNELS-1:0]   Cleaned,
   output logic [CHANNELS-1:0]   Press,
   output logic [CHANNELS-1:0]   Release,
   output logic [CHANNELS-1:0]   LongPress,
   output logic [CHANNELS-1:0]   Repeat,
   output logic                  SampleTick,
   output logic [2*CHANNELS-1:0] o_fsm_state
);

   localparam int DIV  = CLK_HZ / SAMPLE_HZ;
   localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW   = $clog2(STABLE_SAMPLES + 1);
   localparam int HMAX = (LONG_PRESS_SAMPLES > REPEAT_SAMPLES) ? LONG_PRESS_SAMPLES : REPEAT_SAMPLES;
   localparam int HW   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;
   localparam logic [CHANNELS-1:0] SYNC_IDLE = (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      RPT  = 2'd2
   } state_t;

   logic [PW-1:0]       r_presc;
   logic                w_tick;
   logic [CHANNELS-1:0] r_sync1;
   logic [CHANNELS-1:0] r_sync2;
   logic [CHANNELS-1:0] w_s;

   assign w_tick     = (r_presc == PW'(DIV - 1));
   assign SampleTick = w_tick;

   always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
      if (!Rst_n) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // Synchroniser idles at the released level so a reset does not look like a press.
   always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
      if (!Rst_n) begin
         r_sync1 <= SYNC_IDLE;
         r_sync2 <= SYNC_IDLE;
      end else begin
         r_sync1 <= Raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [SW-1:0] r_stab;
      logic          r_clean;
      logic          r_press;
      logic          r_rel;
      logic          r_long;
      logic          r_rep;
      logic          w_flip;
      logic          w_rise;
      logic          w_fall;
      state_t        r_state;
      state_t        w_state_nxt;
      logic [HW-1:0] r_hold;
      logic [HW-1:0] w_hold_nxt;
      logic [HW-1:0] w_hold_inc;
      logic          w_long_nxt;
      logic          w_rep_nxt;

      // The count only advances on disagreeing ticks; the last one flips the level.
      assign w_flip = w_tick && (w_s[c] != r_clean) && (r_stab == SW'(STABLE_SAMPLES - 1));
      assign w_rise = w_flip && w_s[c];
      assign w_fall = w_flip && !w_s[c];

      always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
         if (!Rst_n) begin
            r_stab  <= '0;
            r_clean <= 1'b0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
         end else begin
            r_press <= w_rise;
            r_rel   <= w_fall;
            if (w_tick) begin
               if ((w_s[c] == r_clean) || w_flip) begin
                  r_stab <= '0;
               end else begin
                  r_stab <= r_stab + SW'(1);
               end
               if (w_flip) begin
                  r_clean <= w_s[c];
               end
            end
         end
      end

      assign w_hold_inc = (r_hold == {HW{1'b1}}) ? r_hold : r_hold + HW'(1);

      always_comb begin
         w_state_nxt = r_state;
         w_hold_nxt  = r_hold;
         w_long_nxt  = 1'b0;
         w_rep_nxt   = 1'b0;
         if (w_fall) begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_rise) begin
                     w_state_nxt = HELD;
                     w_hold_nxt  = '0;
                  end
               end
               HELD: begin
                  if (w_tick && r_clean) begin
                     if ((LONG_PRESS_SAMPLES != 0) && (w_hold_inc == HW'(LONG_PRESS_SAMPLES))) begin
                        w_long_nxt  = 1'b1;
                        w_hold_nxt  = '0;
                        w_state_nxt = RPT;
                     end else begin
                        w_hold_nxt = w_hold_inc;
                     end
                  end
               end
               RPT: begin
                  if (w_tick) begin
                     if ((REPEAT_SAMPLES != 0) && (w_hold_inc == HW'(REPEAT_SAMPLES))) begin
                        w_rep_nxt  = 1'b1;
                        w_hold_nxt = '0;
                     end else begin
                        w_hold_nxt = w_hold_inc;
                     end
                  end
               end
               default: begin
                  w_state_nxt = IDLE;
                  w_hold_nxt  = '0;
               end
            endcase
         end
      end

      always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
         if (!Rst_n) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_long  <= 1'b0;
            r_rep   <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_long  <= w_long_nxt;
            r_rep   <= w_rep_nxt;
         end
      end

      assign Cleaned[c]            = r_clean;
      assign Press[c]              = r_press;
      assign Release[c]            = r_rel;
      assign LongPress[c]          = r_long;
      assign Repeat[c]             = r_rep;
      assign o_fsm_state[2*c +: 2] = r_state;
   end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Bench for multi_key_debounce: an active-low and an active-high instance run side by
// side against a tick-level reference model of the debounce and hold-timing rules.
module tb_multi_key_debounce;

   localparam int CH     = 4;
   localparam int DIV    = 10;
   localparam int STABLE = 4;
   localparam int LONG   = 10;
   localparam int REP    = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [CH-1:0]     raw_a, raw_b;
   logic [CH-1:0]     cln_a, prs_a, rel_a, lng_a, rpt_a;
   logic [CH-1:0]     cln_b, prs_b, rel_b, lng_b, rpt_b;
   logic              tick_a, tick_b;
   logic [2*CH-1:0]   st_a, st_b;

   always #5 clk = ~clk;

   multi_key_debounce #(
      .CHANNELS(CH), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_SAMPLES(STABLE),
      .ACTIVE_LOW(1), .LONG_PRESS_SAMPLES(LONG), .REPEAT_SAMPLES(REP)
   ) dut_a (
      .Clk_50Mhz(clk), .Rst_n(rst_n), .Raw(raw_a), .Cleaned(cln_a), .Press(prs_a),
      .Release(rel_a), .LongPress(lng_a), .Repeat(rpt_a), .SampleTick(tick_a),
      .o_fsm_state(st_a)
   );

   multi_key_debounce #(
      .CHANNELS(CH), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_SAMPLES(STABLE),
      .ACTIVE_LOW(0), .LONG_PRESS_SAMPLES(LONG), .REPEAT_SAMPLES(REP)
   ) dut_b (
      .Clk_50Mhz(clk), .Rst_n(rst_n), .Raw(raw_b), .Cleaned(cln_b), .Press(prs_b),
      .Release(rel_b), .LongPress(lng_b), .Repeat(rpt_b), .SampleTick(tick_b),
      .o_fsm_state(st_b)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int lat_press;
   int phase_press;

   // Reference model: edge count since reset, raw history, last STABLE samples per key,
   // and an unbounded count of ticks held since the press.
   int            m_n;
   logic [CH-1:0] m_h1[2], m_h2[2];
   bit            m_samp[2][CH][STABLE];
   logic [CH-1:0] m_clean[2], m_press[2], m_rel[2], m_long[2], m_rpt[2];
   int            m_held[2][CH];
   logic          m_tick;
   logic [41:0]   got, exp_v;

   task automatic model_reset();
      m_n    = 0;
      m_tick = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_h1[i]    = (i == 0) ? '1 : '0;
         m_h2[i]    = (i == 0) ? '1 : '0;
         m_clean[i] = '0;
         m_press[i] = '0;
         m_rel[i]   = '0;
         m_long[i]  = '0;
         m_rpt[i]   = '0;
         for (int c = 0; c < CH; c++) begin
            m_held[i][c] = 0;
            for (int k = 0; k < STABLE; k++) m_samp[i][c][k] = 1'b0;
         end
      end
   endtask

   task automatic model_edge();
      bit s, all_diff;
      m_n++;
      for (int i = 0; i < 2; i++) begin
         m_press[i] = '0;
         m_rel[i]   = '0;
         m_long[i]  = '0;
         m_rpt[i]   = '0;
      end
      if (m_n % DIV == 0) begin
         for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < CH; c++) begin
               s = (i == 0) ? ~m_h2[i][c] : m_h2[i][c];
               for (int k = 0; k < STABLE - 1; k++) m_samp[i][c][k] = m_samp[i][c][k+1];
               m_samp[i][c][STABLE-1] = s;
               all_diff = 1'b1;
               for (int k = 0; k < STABLE; k++) if (m_samp[i][c][k] == m_clean[i][c]) all_diff = 1'b0;
               if (all_diff) begin
                  m_clean[i][c] = s;
                  if (s) m_press[i][c] = 1'b1;
                  else m_rel[i][c] = 1'b1;
                  m_held[i][c] = 0;
               end else if (m_clean[i][c]) begin
                  m_held[i][c]++;
                  if (m_held[i][c] == LONG) m_long[i][c] = 1'b1;
                  else if (m_held[i][c] > LONG && (m_held[i][c] - LONG) % REP == 0) m_rpt[i][c] = 1'b1;
               end
            end
         end
      end
      m_h2[0] = m_h1[0];
      m_h2[1] = m_h1[1];
      m_h1[0] = raw_a;
      m_h1[1] = raw_b;
      m_tick  = (m_n % DIV == DIV - 1);
   endtask

   task automatic sample();
      got   = {cln_a, prs_a, rel_a, lng_a, rpt_a, tick_a, cln_b, prs_b, rel_b, lng_b, rpt_b, tick_b};
      exp_v = {m_clean[0], m_press[0], m_rel[0], m_long[0], m_rpt[0], m_tick,
               m_clean[1], m_press[1], m_rel[1], m_long[1], m_rpt[1], m_tick};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) model_edge();
      else model_reset();
      sample();
   endtask

   task automatic test_reset();
      int first = -1;
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 20; i++) begin
         raw_a = CH'($urandom);
         raw_b = CH'($urandom);
         step();
         checks++;
         if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc, got);
         end
      end
      raw_a = '1;
      raw_b = '0;
      rst_n = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (tick_a && first < 0) first = i;
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, got, exp_v);
         end
      end
      // Prescaler reaches DIV-1 after DIV-1 edges, i.e. during the DIV-th cycle.
      checks++;
      if (first != DIV - 1) begin
         errors++;
         $display("FAIL first_tick edge=%0d exp=%0d", first, DIV - 1);
      end
   endtask

   task automatic test_clean_press();
      int t0, rise = -1, pcyc = -1, pcnt = 0;
      logic [CH-1:0] others = '0;
      for (int i = 0; i < int'($urandom_range(0, 9)); i++) step();
      phase_press = m_n % DIV;
      t0 = cyc;
      raw_a[0] = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL clean_press cyc=%0d got=%h exp=%h", cyc, got, exp_v);
         end
         if (cln_a[0] && rise < 0) rise = cyc - t0;
         if (prs_a[0]) begin
            pcnt++;
            pcyc = cyc - t0;
         end
         others |= {cln_a[3:1], 1'b0} | {prs_a[3:1], 1'b0};
      end
      lat_press = rise;
      checks++;
      if (rise < 1 || rise > 2 + STABLE * DIV) begin
         errors++;
         $display("FAIL press_latency got=%0d max=%0d", rise, 2 + STABLE * DIV);
      end
      checks++;
      if (pcnt != 1 || pcyc != rise) begin
         errors++;
         $display("FAIL press_pulse count=%0d at=%0d exp count=1 at=%0d", pcnt, pcyc, rise);
      end
      checks++;
      if (others !== '0) begin
         errors++;
         $display("FAIL press_isolation got=%b exp=0000", others);
      end
      raw_a[0] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL clean_release cyc=%0d got=%h exp=%h", cyc, got, exp_v);
         end
      end
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 500; i++) begin
         if (i % 25 == 0) raw_a[1] = ~raw_a[1];
         step();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL bounce_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
         end
         checks++;
         if ({cln_a[1], prs_a[1], rel_a[1]} !== 3'b000) begin
            errors++;
            $display("FAIL bounce_leak cyc=%0d got=%b exp=000", cyc, {cln_a[1], prs_a[1], rel_a[1]});
         end
      end
      raw_a[1] = 1'b1;
      for (int i = 0; i < 50; i++) step();
   endtask

   task automatic test_long_repeat();
      int p = -1, l = -1, nrel = 0, post_rpt = 0;
      int rep_q[$];
      raw_a[2] = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL long_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
         end
         if (prs_a[2]) p = cyc;
         if (lng_a[2]) l = cyc;
         if (rpt_a[2]) rep_q.push_back(cyc);
      end
      checks++;
      if (p < 0 || l - p != LONG * DIV) begin
         errors++;
         $display("FAIL long_delay got=%0d exp=%0d", l - p, LONG * DIV);
      end
      checks++;
      if (rep_q.size() < 3) begin
         errors++;
         $display("FAIL repeat_count got=%0d exp>=3", rep_q.size());
      end
      for (int k = 0; k < rep_q.size(); k++) begin
         checks++;
         if (rep_q[k] - ((k == 0) ? l : rep_q[k-1]) != REP * DIV) begin
            errors++;
            $display("FAIL repeat_period idx=%0d got=%0d exp=%0d", k,
                     rep_q[k] - ((k == 0) ? l : rep_q[k-1]), REP * DIV);
         end
      end
      raw_a[2] = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL long_release cyc=%0d got=%h exp=%h", cyc, got, exp_v);
         end
         if (rel_a[2]) nrel++;
         if (nrel > 0 && rpt_a[2]) post_rpt++;
      end
      checks++;
      if (nrel != 1 || post_rpt != 0) begin
         errors++;
         $display("FAIL release_after_hold releases=%0d repeats=%0d exp 1 and 0", nrel, post_rpt);
      end
   endtask

   task automatic test_simultaneous_reset();
      int p0 = -1, p3 = -1, pn = -1;
      raw_a[0] = 1'b0;
      raw_a[3] = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL simul_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
         end
         if (prs_a[0]) p0 = cyc;
         if (prs_a[3]) p3 = cyc;
      end
      checks++;
      if (p0 < 0 || p0 != p3) begin
         errors++;
         $display("FAIL simul_press ch0=%0d ch3=%0d exp equal", p0, p3);
      end
      for (int i = 0; i < int'($urandom_range(5, 30)); i++) step();
      rst_n = 1'b0;
      #1;
      model_reset();
      sample();
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL midpress_reset got=%h exp=0", got);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (got !== '0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=0", cyc, got);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL fresh_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
         end
         if (prs_a[0] && prs_a[3] && pn < 0) pn = m_n;
      end
      checks++;
      if (pn != STABLE * DIV) begin
         errors++;
         $display("FAIL fresh_press edge=%0d exp=%0d", pn, STABLE * DIV);
      end
      raw_a = '1;
      for (int i = 0; i < 60; i++) step();
   endtask

   task automatic test_polarity();
      int t0, rise = -1, pcyc = -1;
      for (int i = 0; i < DIV && (m_n % DIV) != phase_press; i++) step();
      t0 = cyc;
      raw_b[0] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL polarity_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
         end
         if (cln_b[0] && rise < 0) rise = cyc - t0;
         if (prs_b[0] && pcyc < 0) pcyc = cyc - t0;
      end
      checks++;
      if (rise != lat_press || pcyc != rise) begin
         errors++;
         $display("FAIL polarity_timing rise=%0d press=%0d exp=%0d", rise, pcyc, lat_press);
      end
      raw_b[0] = 1'b0;
      for (int i = 0; i < 60; i++) step();
   endtask

   task automatic test_random();
      int next_chg[8];
      for (int b = 0; b < 8; b++) next_chg[b] = cyc + int'($urandom_range(5, 250));
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 8; b++) begin
            if (cyc >= next_chg[b]) begin
               if (b < 4) raw_a[b] = ~raw_a[b];
               else raw_b[b-4] = ~raw_b[b-4];
               next_chg[b] = cyc + (($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 25))
                                                                : int'($urandom_range(30, 250)));
            end
         end
         step();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp_v);
         end
      end
      raw_a = '1;
      raw_b = '0;
      for (int i = 0; i < 60; i++) begin
         step();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, got, exp_v);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      raw_a = '1;
      raw_b = '0;
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_repeat();
      test_simultaneous_reset();
      test_polarity();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
